// File: rtl/maze_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : maze_mem_arbiter
// Description : Shares the single-port 256x16 maze cell RAM between the VGA
//               pixel fetch, the maze generator engine and an internal clear
//               sweep that fills every cell with the wall value.
//               One RAM grant per cycle.
//               Priority: forced generator > display > clear write > generator.
//               Read data returns two cycles after the grant through a
//               registered owner pipe.
// Options     : `define MAZE_ARB_STARVE_EN enables the generator starvation
//               guard. This adds a starve counter, forced grants and the
//               disp_miss pulse. Without it, disp_miss is tied low.
// Ports       : clk/rst_n        clock, async active-low reset
//               clear_start/busy clear sweep control and status
//               disp_*           display read request / registered response
//               gen_*            generator valid/ready request / response
//               mem_*            RAM macro interface (mem_rdata 1-cycle latency)
// Revision    : 1.0  initial release
// ============================================================================
module maze_mem_arbiter #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = 16'hFFFF,
    parameter int                STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_start,
    output logic              clear_busy,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_miss,
    input  logic              gen_valid,
    output logic              gen_ready,
    input  logic              gen_we,
    input  logic [ADDR_W-1:0] gen_addr,
    input  logic [DATA_W-1:0] gen_wdata,
    output logic              gen_rvalid,
    output logic [DATA_W-1:0] gen_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_p1_vld;      // a read was granted last cycle
    logic              r_p1_gen;      // ...and it belongs to the generator
    logic              r_disp_rvalid;
    logic [DATA_W-1:0] r_disp_rdata;
    logic              r_gen_rvalid;
    logic [DATA_W-1:0] r_gen_rdata;

    logic w_force;
    logic w_in_clear;
    logic w_gnt_disp;
    logic w_gnt_clr;
    logic w_gen_xfer;
    logic w_gen_rd;

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
`ifdef MAZE_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] r_starve;
    logic          r_p1_miss;
    logic          r_disp_miss;

    // The cycle after the counter reaches STARVE_MAX belongs to the generator.
    assign w_force = (r_starve == SW'(STARVE_MAX));

    // Only display contention counts toward starvation. A generator blocked
    // purely by the clear sweep holds the count instead of advancing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_force || w_gen_xfer || !gen_valid) begin
            r_starve <= '0;
        end else if (!gen_ready && disp_req) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    // A display request dropped by a forced grant reports back on the same
    // N+2 slot where its read data would have arrived.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_miss   <= 1'b0;
            r_disp_miss <= 1'b0;
        end else begin
            r_p1_miss   <= disp_req & w_force;
            r_disp_miss <= r_p1_miss;
        end
    end

    assign disp_miss = r_disp_miss;
`else
    assign w_force   = 1'b0;
    assign disp_miss = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Grant decode
    // ------------------------------------------------------------------
    // rst_n is folded in so the RAM sees no enable while reset is held.
    assign w_in_clear = (r_state == S_CLEAR);
    assign w_gnt_disp = rst_n & disp_req & ~w_force;
    assign w_gnt_clr  = rst_n & w_in_clear & ~disp_req & ~w_force;
    assign gen_ready  = rst_n & (w_force | (~w_in_clear & ~disp_req));
    assign w_gen_xfer = gen_valid & gen_ready;
    assign w_gen_rd   = w_gen_xfer & ~gen_we;

    assign mem_en = w_gnt_disp | w_gnt_clr | w_gen_xfer;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt_disp) begin
            mem_addr = disp_addr;
        end else if (w_gnt_clr) begin
            mem_we    = 1'b1;
            mem_addr  = r_clr_cnt;
            mem_wdata = CLEAR_VAL;
        end else if (w_gen_xfer) begin
            mem_we    = gen_we;
            mem_addr  = gen_addr;
            mem_wdata = gen_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Clear sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear_start) begin
                        r_state   <= S_CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
                S_CLEAR: begin
                    // Advance only on a granted write. Display reads may
                    // stretch the sweep.
                    if (w_gnt_clr) begin
                        if (r_clr_cnt == {ADDR_W{1'b1}}) begin
                            r_state <= S_IDLE;
                        end
                        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign clear_busy = w_in_clear;

    // ------------------------------------------------------------------
    // Read return path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_vld      <= 1'b0;
            r_p1_gen      <= 1'b0;
            r_disp_rvalid <= 1'b0;
            r_disp_rdata  <= '0;
            r_gen_rvalid  <= 1'b0;
            r_gen_rdata   <= '0;
        end else begin
            r_p1_vld      <= w_gnt_disp | w_gen_rd;
            r_p1_gen      <= w_gen_rd;
            r_disp_rvalid <= r_p1_vld & ~r_p1_gen;
            r_gen_rvalid  <= r_p1_vld & r_p1_gen;
            // Data registers hold their last value between valid beats.
            if (r_p1_vld && !r_p1_gen) begin
                r_disp_rdata <= mem_rdata;
            end
            if (r_p1_vld && r_p1_gen) begin
                r_gen_rdata <= mem_rdata;
            end
        end
    end

    assign disp_rvalid = r_disp_rvalid;
    assign disp_rdata  = r_disp_rdata;
    assign gen_rvalid  = r_gen_rvalid;
    assign gen_rdata   = r_gen_rdata;

endmodule
`default_nettype wire

// File: tb/tb_maze_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_mem_arbiter
// Description : Self-checking bench for maze_mem_arbiter.
//               It contains a behavioural RAM and a transaction-level reference
//               model. The model uses a shadow cell array and an expected-
//               response queue.
//               Honours MAZE_ARB_STARVE_EN when defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_maze_mem_arbiter;

    localparam logic [15:0] CLR  = 16'hFFFF;
    localparam int          SMAX = 8;
`ifdef MAZE_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic        clk, rst_n, clear_start, clear_busy;
    logic        disp_req, disp_rvalid, disp_miss;
    logic [7:0]  disp_addr;
    logic [15:0] disp_rdata;
    logic        gen_valid, gen_ready, gen_we, gen_rvalid;
    logic [7:0]  gen_addr;
    logic [15:0] gen_wdata, gen_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    maze_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata), .disp_miss(disp_miss),
        .gen_valid(gen_valid), .gen_ready(gen_ready), .gen_we(gen_we),
        .gen_addr(gen_addr), .gen_wdata(gen_wdata),
        .gen_rvalid(gen_rvalid), .gen_rdata(gen_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: synchronous read, one-cycle latency.
    logic [15:0] ram [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        int          due;
        bit          gen;
        bit          miss;
        logic [15:0] data;
    } exp_t;

    logic [15:0] mm [256];   // what every cell should hold
    exp_t        q[$];       // responses owed, ordered by due cycle
    bit          m_clr;
    int          m_cnt, m_starve, cyc;
    logic [15:0] m_drd, m_grd;

    int n_vec, n_err, n_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_clr    = 1'b0;
        m_cnt    = 0;
        m_starve = 0;
        m_drd    = '0;
        m_grd    = '0;
        q.delete();
    endtask

    // Hit reset while traffic is active. All outputs must be quiet at once.
    task automatic do_reset();
        clear_start = 1'b1;
        disp_req    = 1'b1;
        gen_valid   = 1'b1;
        gen_we      = 1'($urandom);
        rst_n       = 1'b0;
        #2;
        check("rst_clear_busy", clear_busy, 0);
        check("rst_disp_rvalid", disp_rvalid, 0);
        check("rst_disp_rdata", disp_rdata, 0);
        check("rst_gen_rvalid", gen_rvalid, 0);
        check("rst_gen_rdata", gen_rdata, 0);
        check("rst_disp_miss", disp_miss, 0);
        check("rst_gen_ready", gen_ready, 0);
        check("rst_mem_en", mem_en, 0);
        clear_start = 1'b0;
        disp_req    = 1'b0;
        gen_valid   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        model_reset();
    endtask

    // One clock cycle. The task is entered and left 1 time unit after a
    // rising edge.
    task automatic step(input bit cs, input bit dr, input logic [7:0] da,
                        input bit gv, input bit gwe, input logic [7:0] ga,
                        input logic [15:0] gwd);
        bit   frc, g_disp, g_clr, rdy, e_dv, e_gv, e_miss;
        exp_t e;
        clear_start = cs;
        disp_req    = dr;
        disp_addr   = da;
        gen_valid   = gv;
        gen_we      = gwe;
        gen_addr    = ga;
        gen_wdata   = gwd;
        #3;
        // Who owns the RAM this cycle?
        frc    = STARVE_EN && (m_starve == SMAX);
        g_disp = dr && !frc;
        g_clr  = m_clr && !dr && !frc;
        rdy    = frc || (!m_clr && !dr);
        check("gen_ready", gen_ready, rdy);
        if (gen_ready) n_ready++;
        check("mem_en", mem_en, g_disp || g_clr || (gv && rdy));
        if (g_disp) begin
            check("disp_mem_addr", mem_addr, da);
            check("disp_mem_we", mem_we, 0);
            q.push_back('{due: cyc + 2, gen: 1'b0, miss: 1'b0, data: mm[da]});
        end else if (g_clr) begin
            check("clr_mem_addr", mem_addr, m_cnt);
            check("clr_mem_we", mem_we, 1);
            check("clr_mem_wdata", mem_wdata, CLR);
            mm[m_cnt] = CLR;
        end else if (gv && rdy) begin
            check("gen_mem_addr", mem_addr, ga);
            check("gen_mem_we", mem_we, gwe);
            if (gwe) begin
                check("gen_mem_wdata", mem_wdata, gwd);
                mm[ga] = gwd;
            end else begin
                q.push_back('{due: cyc + 2, gen: 1'b1, miss: 1'b0, data: mm[ga]});
            end
        end
        if (frc && dr)
            q.push_back('{due: cyc + 2, gen: 1'b0, miss: 1'b1, data: 16'h0});
        // Starvation bookkeeping: only display-blocked cycles count.
        if (frc || (gv && rdy) || !gv) m_starve = 0;
        else if (dr)                   m_starve++;
        // Sweep progress.
        if (m_clr) begin
            if (g_clr) begin
                if (m_cnt == 255) m_clr = 1'b0;
                m_cnt++;
            end
        end else if (cs) begin
            m_clr = 1'b1;
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        e_dv = 0; e_gv = 0; e_miss = 0;
        while (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (e.miss)     e_miss = 1;
            else if (e.gen) begin e_gv = 1; m_grd = e.data; end
            else            begin e_dv = 1; m_drd = e.data; end
        end
        check("clear_busy", clear_busy, m_clr);
        check("disp_rvalid", disp_rvalid, e_dv);
        check("disp_rdata", disp_rdata, m_drd);
        check("gen_rvalid", gen_rvalid, e_gv);
        check("gen_rdata", gen_rdata, m_grd);
        check("disp_miss", disp_miss, e_miss);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h0, 0, 0, 8'h0, 16'h0);
    endtask

    int n_busy;

    initial begin
        clk = 1'b0; rst_n = 1'b1; clear_start = 1'b0; disp_req = 1'b0;
        disp_addr = '0; gen_valid = 1'b0; gen_we = 1'b0; gen_addr = '0;
        gen_wdata = '0; mem_rdata = '0;
        n_vec = 0; n_err = 0; cyc = 0; n_ready = 0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 16'h0;
            mm[i]  = 16'h0;
        end
        model_reset();
        #2;
        do_reset();

        // Display read of a zero cell.
        step(0, 1, 8'h21, 0, 0, 8'h0, 16'h0);
        idle(2);

        // Generator write then read back. Back-to-back reads are also tested.
        step(0, 0, 8'h0, 1, 1, 8'h77, 16'h5A5A);
        step(0, 0, 8'h0, 1, 0, 8'h77, 16'h0);
        step(0, 1, 8'h77, 0, 0, 8'h0, 16'h0);
        idle(2);

        // Clear sweep with no display traffic, retriggered mid-sweep. The
        // generator keeps asking and must be refused until the sweep ends.
        step(1, 0, 8'h0, 1, 0, 8'($urandom), 16'h0);
        n_busy = 0;
        for (int i = 0; i < 600 && clear_busy; i++) begin
            step(i == 100, 0, 8'h0, 1, 0, 8'($urandom), 16'h0);
            n_busy++;
        end
        check("clear_len", n_busy, 256);
        step(0, 1, 8'h00, 0, 0, 8'h0, 16'h0);
        step(0, 1, 8'hFF, 0, 0, 8'h0, 16'h0);
        idle(2);

        // Put some non-wall data back, then sweep with display every other cycle.
        for (int i = 0; i < 16; i++) step(0, 0, 8'h0, 1, 1, 8'(i * 17), 16'($urandom));
        step(1, 0, 8'h0, 0, 0, 8'h0, 16'h0);
        n_busy = 0;
        for (int i = 0; i < 1200 && clear_busy; i++) begin
            step(0, (i % 2) == 0, 8'($urandom), 0, 0, 8'h0, 16'h0);
            n_busy++;
        end
        check("clear_len_contended", n_busy, 512);
        idle(2);

        // Display and generator both held high.
        n_ready = 0;
        for (int i = 0; i < 27; i++) step(0, 1, 8'($urandom), 1, 0, 8'($urandom), 16'h0);
        check("starve_grants", n_ready, STARVE_EN ? 3 : 0);
        idle(2);

        // Random traffic. Generator addresses stay in a narrow window so that
        // read-after-write hits are frequent. Reset lands mid-run.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            step(($urandom % 150) == 0, ($urandom % 3) == 0, 8'($urandom % 16),
                 ($urandom % 4) != 0, 1'($urandom), 8'($urandom % 16), 16'($urandom));
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
